conv_kernel_mac: RTL and testbench

Sequential fixed-point K×K convolution MAC engine for the CNN datapath. It is the parametrised successor to the single-product float filter check. It holds a loadable K×K weight bank and accepts one output window's K×K pixels over a valid/ready stream. It accumulates bias + Σ pixel·weight in a widened accumulator, then rounds, saturates and optionally applies ReLU. The result is presented on a valid/ready output. It sits between the line-buffer/window generator and the pooling stage.

---
 rtl/conv_kernel_mac.sv | 129 ++++++++++++
 tb/tb_conv_kernel_mac.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_kernel_mac.sv
// Sequential fixed-point KxK convolution MAC: loadable weight bank, one window
// streamed in per run, bias + sum of products rounded, saturated and optionally ReLU'd.
module conv_kernel_mac #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int K      = 3,
    parameter int ACC_W  = 40,
    localparam int TAPS  = K * K,
    localparam int AW    = (TAPS > 1) ? $clog2(TAPS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              w_we,
    input  logic [AW-1:0]     w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              start,
    input  logic [DATA_W-1:0] bias,
    input  logic              relu_en,
    input  logic              px_valid,
    input  logic [DATA_W-1:0] px_data,
    output logic              px_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_ovf,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCUM, ROUND, OUT} state_t;

    localparam logic signed [ACC_W-1:0] HALF    = ACC_W'(1) << (FRAC_W - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    state_t                     state;
    state_t                     state_next;
    logic signed [DATA_W-1:0]   weights [TAPS];
    logic signed [ACC_W-1:0]    acc;
    logic        [AW-1:0]       tap;
    logic                       relu_q;
    logic                       px_fire;
    logic                       last_tap;
    logic signed [2*DATA_W-1:0] product;
    logic signed [ACC_W-1:0]    acc_half;
    logic signed [ACC_W-1:0]    rounded;
    logic        [DATA_W-1:0]   sat_data;
    logic                       sat_ovf;

    assign px_ready  = (state == ACCUM);
    assign out_valid = (state == OUT);
    assign busy      = (state != IDLE);
    assign px_fire   = px_valid && (state == ACCUM);
    assign last_tap  = (tap == AW'(TAPS - 1));
    assign product   = $signed(px_data) * weights[tap];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ACCUM;
            ACCUM:   if (px_fire && last_tap) state_next = ROUND;
            ROUND:   state_next = OUT;
            OUT:     if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A write coinciding with start lands at that edge, before tap 0 is read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                weights[i] <= '0;
            end
        end else if (state == IDLE && w_we && (32'(w_addr) < TAPS)) begin
            weights[w_addr] <= w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc    <= '0;
            tap    <= '0;
            relu_q <= 1'b0;
        end else if (state == IDLE && start) begin
            acc    <= {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias} <<< FRAC_W;
            tap    <= '0;
            relu_q <= relu_en;
        end else if (px_fire) begin
            acc <= acc + {{(ACC_W-2*DATA_W){product[2*DATA_W-1]}}, product};
            tap <= tap + AW'(1);
        end
    end

    // Round half up, clip to the output range, then ReLU; ovf reports the clip only.
    always_comb begin
        acc_half = acc + HALF;
        rounded  = acc_half >>> FRAC_W;
        sat_data = rounded[DATA_W-1:0];
        sat_ovf  = 1'b0;
        if (rounded > SAT_MAX) begin
            sat_data = SAT_MAX[DATA_W-1:0];
            sat_ovf  = 1'b1;
        end else if (rounded < SAT_MIN) begin
            sat_data = SAT_MIN[DATA_W-1:0];
            sat_ovf  = 1'b1;
        end
        if (relu_q && sat_data[DATA_W-1]) begin
            sat_data = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data <= '0;
            out_ovf  <= 1'b0;
        end else if (state == ROUND) begin
            out_data <= sat_data;
            out_ovf  <= sat_ovf;
        end
    end

endmodule

// File: tb/tb_conv_kernel_mac.sv
// Directed, table-driven bench for conv_kernel_mac with default parameters
// (Q8.8, 3x3 kernel) plus backpressure and mid-window reset sequences.
module tb_conv_kernel_mac;

    localparam int DATA_W = 16;
    localparam int TAPS   = 9;
    localparam int AW     = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              w_we;
    logic [AW-1:0]     w_addr;
    logic [DATA_W-1:0] w_data;
    logic              start;
    logic [DATA_W-1:0] bias;
    logic              relu_en;
    logic              px_valid;
    logic [DATA_W-1:0] px_data;
    logic              px_ready;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_ovf;
    logic              busy;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [15:0] w0;
        logic [15:0] w_rest;
        logic [15:0] p0;
        logic [15:0] p_base;
        logic [15:0] p_step;
        logic [15:0] bias;
        logic        relu;
        logic [15:0] exp_data;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs [9];

    conv_kernel_mac dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .w_we      (w_we),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .start     (start),
        .bias      (bias),
        .relu_en   (relu_en),
        .px_valid  (px_valid),
        .px_data   (px_data),
        .px_ready  (px_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Runs one window; cycle count 1 is the cycle right after the start edge.
    task automatic apply_stimulus(input vec_t v, input bit load_w, input bit stall, input int hold,
                                  output logic [15:0] got_data, output logic got_ovf,
                                  output int latency);
        int  cycles;
        int  i;
        bit  accept;
        out_ready = (hold == 0);
        if (load_w) begin
            for (int t = 0; t < TAPS - 1; t++) begin
                w_we   = 1'b1;
                w_addr = AW'(t);
                w_data = (t == 0) ? v.w0 : v.w_rest;
                @(posedge clk); #1;
            end
        end
        w_we    = load_w;
        w_addr  = AW'(TAPS - 1);
        w_data  = v.w_rest;
        start   = 1'b1;
        bias    = v.bias;
        relu_en = v.relu;
        @(posedge clk); #1;
        w_we   = 1'b0;
        start  = 1'b0;
        cycles = 1;
        i      = 0;
        while (i < TAPS && cycles < 200) begin
            px_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            px_data  = (i == 0) ? v.p0 : v.p_base + 16'(i) * v.p_step;
            if (stall) begin
                w_we   = 1'($urandom_range(0, 1));
                w_addr = '0;
                w_data = 16'h7FFF;
                start  = 1'($urandom_range(0, 1));
            end
            accept = px_valid && px_ready;
            @(posedge clk); #1;
            cycles++;
            if (accept) i++;
        end
        px_valid = 1'b0;
        w_we     = 1'b0;
        start    = 1'b0;
        while (!out_valid && cycles < 200) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (!out_valid) check_output("out_valid timeout", 32'(out_valid), 32'd1);
        latency  = cycles;
        got_data = out_data;
        got_ovf  = out_ovf;
        check_output("px_ready low in OUT", 32'(px_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            start  = 1'b1;
            w_we   = 1'b1;
            w_addr = '0;
            w_data = 16'h7FFF;
            @(posedge clk); #1;
            check_output("out_valid held", 32'(out_valid), 32'd1);
            check_output("out_data stable", 32'(out_data), 32'(got_data));
        end
        start     = 1'b0;
        w_we      = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_output("out_valid after handshake", 32'(out_valid), 32'd0);
        check_output("busy after handshake", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [15:0] d;
        logic        o;
        int          lat;
        vec_t        bias_only;

        //            w0       w_rest   p0       p_base   p_step   bias     relu  exp      ovf
        vecs[0] = '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0000, 1'b0, 16'h2D00, 1'b0};
        vecs[1] = '{16'hFF00, 16'hFF00, 16'h0200, 16'h0200, 16'h0000, 16'h0100, 1'b0, 16'hEF00, 1'b0};
        vecs[2] = '{16'hFF00, 16'hFF00, 16'h0200, 16'h0200, 16'h0000, 16'h0100, 1'b1, 16'h0000, 1'b0};
        vecs[3] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000, 1'b0, 16'h7FFF, 1'b1};
        vecs[4] = '{16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000, 1'b0, 16'h8000, 1'b1};
        vecs[5] = '{16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1};
        vecs[6] = '{16'h0080, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0001, 1'b0};
        vecs[7] = '{16'h0080, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[8] = '{16'h0080, 16'h0000, 16'h0003, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0002, 1'b0};
        bias_only = '{16'h0000, 16'h0000, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 1'b0, 16'h0100, 1'b0};

        rst_n     = 1'b0;
        w_we      = 1'b0;
        w_addr    = '0;
        w_data    = '0;
        start     = 1'b0;
        bias      = '0;
        relu_en   = 1'b0;
        px_valid  = 1'b0;
        px_data   = '0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_output("reset px_ready", 32'(px_ready), 32'd0);
        check_output("reset out_valid", 32'(out_valid), 32'd0);
        check_output("reset out_data", 32'(out_data), 32'd0);
        check_output("reset out_ovf", 32'(out_ovf), 32'd0);
        check_output("reset busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 9; v++) begin
            apply_stimulus(vecs[v], 1'b1, 1'b0, 0, d, o, lat);
            check_output($sformatf("vec%0d out_data", v), 32'(d), 32'(vecs[v].exp_data));
            check_output($sformatf("vec%0d out_ovf", v), 32'(o), 32'(vecs[v].exp_ovf));
            check_output($sformatf("vec%0d latency", v), 32'(lat), 32'd11);
        end

        // Random pixel stalls, held output, ignored writes/starts.
        apply_stimulus(vecs[0], 1'b1, 1'b1, 5, d, o, lat);
        check_output("backpressure out_data", 32'(d), 32'h2D00);
        check_output("backpressure out_ovf", 32'(o), 32'd0);
        @(posedge clk); #1;
        check_output("no extra window", 32'(busy), 32'd0);
        apply_stimulus(vecs[0], 1'b0, 1'b0, 0, d, o, lat);
        check_output("weights persist", 32'(d), 32'h2D00);

        // Reset after four accepted pixels.
        for (int t = 0; t < TAPS; t++) begin
            w_we   = 1'b1;
            w_addr = AW'(t);
            w_data = 16'h0100;
            @(posedge clk); #1;
        end
        w_we  = 1'b0;
        start = 1'b1;
        bias  = '0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            px_valid = 1'b1;
            px_data  = 16'h0100 + 16'(i) * 16'h0100;
            @(posedge clk); #1;
        end
        px_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk); #1;
        check_output("midreset px_ready", 32'(px_ready), 32'd0);
        check_output("midreset out_valid", 32'(out_valid), 32'd0);
        check_output("midreset out_data", 32'(out_data), 32'd0);
        check_output("midreset out_ovf", 32'(out_ovf), 32'd0);
        check_output("midreset busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        apply_stimulus(bias_only, 1'b0, 1'b0, 0, d, o, lat);
        check_output("weights cleared", 32'(d), 32'h0100);
        apply_stimulus(vecs[0], 1'b1, 1'b0, 0, d, o, lat);
        check_output("after reload out_data", 32'(d), 32'h2D00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
